// File: rtl/nt_stim_pkg.sv
// nt_stim_pkg: shared state encoding, default LFSR constants and the Galois step used by LFSR and MISR.
package nt_stim_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int MAX_W = 64;
  localparam logic [15:0] DEF_SEED = 16'hACE1;
  localparam logic [15:0] DEF_POLY = 16'hB400;
  function automatic logic [MAX_W-1:0] lfsr_step(input logic [MAX_W-1:0] v, input logic [MAX_W-1:0] poly);
    return (v >> 1) ^ (v[0] ? poly : '0);
  endfunction
endpackage

// File: rtl/nt_misr.sv
// nt_misr: single-input Galois MISR compacting the subcircuit response bit.
module nt_misr
  import nt_stim_pkg::*;
#(
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] POLY = LFSR_W'(DEF_POLY)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              d,
  output logic [LFSR_W-1:0] sig
);
  always_ff @(posedge clk)
    if (rst || clr) sig <= '0;
    else if (en) sig <= LFSR_W'(lfsr_step(MAX_W'(sig), MAX_W'(POLY))) ^ LFSR_W'(d);
endmodule

// File: rtl/nt_subckt_stim_gen.sv
// nt_subckt_stim_gen: LFSR stimulus generator with latency-aligned MISR response capture.
// Optional STIM_PAUSE_EN adds a pause input that stalls pattern issue in RUN.
module nt_subckt_stim_gen
  import nt_stim_pkg::*;
#(
  parameter int N_IN = 6,
  parameter int LFSR_W = 16,
  parameter int N_PAT = 1000,
  parameter int LAT = 2,
  parameter logic [LFSR_W-1:0] SEED = LFSR_W'(DEF_SEED),
  parameter logic [LFSR_W-1:0] POLY = LFSR_W'(DEF_POLY)
) (
  input  logic                       I1470_clk,
  input  logic                       I1477_rst,
  input  logic                       start,
  input  logic                       seed_ld,
  input  logic [LFSR_W-1:0]          seed_in,
  input  logic                       resp_in,
`ifdef STIM_PAUSE_EN
  input  logic                       pause,
`endif
  output logic [N_IN-1:0]            stim_out,
  output logic                       stim_valid,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(N_PAT+1)-1:0] pat_cnt,
  output logic [LFSR_W-1:0]          signature
);
  localparam int CW = $clog2(N_PAT+1);
  localparam int DW = $clog2(LAT+1);
  state_t state, state_nx;
  logic [LFSR_W-1:0] lfsr;
  logic [N_IN-1:0] last_q;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dcnt;
  logic [LAT-1:0] pipe;
  logic hold, idle_done, go, ld, issue, last;
`ifdef STIM_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif
  assign idle_done = state == IDLE || state == DONE;
  assign go = start && idle_done;
  assign ld = seed_ld && idle_done;
  assign issue = state == RUN && !hold;
  assign last = issue && cnt == CW'(N_PAT-1);
  always_comb begin
    state_nx = go ? RUN
             : last ? DRAIN
             : (state == DRAIN && dcnt == DW'(LAT-1)) ? DONE
             : state;
  end
  always_ff @(posedge I1470_clk) begin
    if (I1477_rst) begin
      state  <= IDLE;
      lfsr   <= SEED;
      last_q <= '0;
      cnt    <= '0;
      dcnt   <= '0;
      pipe   <= '0;
    end else begin
      state  <= state_nx;
      lfsr   <= ld ? (seed_in == '0 ? SEED : seed_in)
              : issue ? LFSR_W'(lfsr_step(MAX_W'(lfsr), MAX_W'(POLY)))
              : lfsr;
      last_q <= issue ? lfsr[N_IN-1:0] : last_q;
      cnt    <= go ? '0 : (issue && cnt != CW'(N_PAT)) ? cnt + CW'(1) : cnt;
      dcnt   <= state == DRAIN ? dcnt + DW'(1) : '0;
      pipe   <= LAT'({pipe, issue});
    end
  end
  // Delayed valid marks the cycle in which that pattern's response is present.
  nt_misr #(.LFSR_W(LFSR_W), .POLY(POLY)) u_misr (
    .clk(I1470_clk),
    .rst(I1477_rst),
    .clr(go),
    .en (pipe[LAT-1]),
    .d  (resp_in),
    .sig(signature)
  );
  assign stim_valid = issue;
  assign stim_out   = issue ? lfsr[N_IN-1:0] : last_q;
  assign busy       = state == RUN || state == DRAIN;
  assign done       = state == DONE;
  assign pat_cnt    = cnt;
endmodule
